// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the serial add/subtract unit.
//   state_t  : sequencer states (IDLE -> RUN x NIBBLES -> DONE)
//   NIB_W    : width of the carry-lookahead slice
//   SAT_POS  : saturation value for positive overflow
//   SAT_NEG  : saturation value for negative overflow
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/cla_nibble_slice.sv
// ---------------------------------------------------------------------------
// cla_nibble_slice
// Combinational 4-bit carry-lookahead adder slice.
//   a, b : nibble operands (b already inverted by the parent for subtract)
//   cin  : carry into bit 0
//   sum  : nibble sum
//   c3   : carry out of bit 3
//   c2   : carry into bit 3 (used by the parent for signed overflow)
// ---------------------------------------------------------------------------
module cla_nibble_slice
    import alu_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             c3,
    output logic             c2
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;
        // Every carry is expanded from generate/propagate terms so none of
        // them ripples through the previous bit.
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        c3   = c[4];
        c2   = c[3];
    end

endmodule

// File: rtl/serial_addsub16.sv
// ---------------------------------------------------------------------------
// serial_addsub16
// Multi-cycle add/subtract: one 4-bit CLA slice processes one nibble per
// cycle, LSB nibble first. Operands are captured on an accepted start, the
// result and Z/N/V flags are valid on the one-cycle done pulse.
//
// Handshake: start is accepted only in IDLE or DONE and only when flush is
// low; start while busy is dropped, not queued. flush aborts a running
// operation (no done pulse, flags untouched) and returns to IDLE.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start, flush : request / synchronous abort
//   sub, A, B    : operation select and operands, sampled with start
//   busy, done   : RUN indicator, one-cycle result-valid pulse
//   Result,Z,N,V : result and flags, held until the next operation
//
// Build option: define SERIAL_ADDSUB_SAT_EN to saturate Result on signed
// overflow (7FFF / 8000 by the sign of A). Without it the result wraps.
// ---------------------------------------------------------------------------
module serial_addsub16
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             N,
    output logic             V
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;

    logic             accept;
    logic             last_nib;
    logic [NIB_W-1:0] slice_a;
    logic [NIB_W-1:0] slice_b;
    logic [NIB_W-1:0] slice_sum;
    logic             slice_c3;
    logic             slice_c2;

    assign accept   = ((state_q == IDLE) || (state_q == DONE)) && start && !flush;
    assign last_nib = (idx_q == LAST_IDX);
    assign slice_a  = op_a_q[int'(idx_q)*NIB_W +: NIB_W];
    assign slice_b  = op_b_q[int'(idx_q)*NIB_W +: NIB_W];

    cla_nibble_slice u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .sum (slice_sum),
        .c3  (slice_c3),
        .c2  (slice_c2)
    );

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (flush)         state_d = IDLE;
                else if (last_nib) state_d = DONE;
            end
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy   = (state_q == RUN);
        done   = (state_q == DONE);
        Result = result_q;
        Z      = z_q;
        N      = n_q;
        V      = v_q;
    end

    // Datapath: operand capture, per-nibble accumulate, final flags.
    always_comb begin
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        if (accept) begin
            // Subtraction is A + ~B + 1: invert here, inject the +1 as carry.
            op_a_d  = A;
            op_b_d  = sub ? ~B : B;
            carry_d = sub;
            idx_d   = '0;
        end else if ((state_q == RUN) && !flush) begin
            result_d[int'(idx_q)*NIB_W +: NIB_W] = slice_sum;
            carry_d = slice_c3;
            idx_d   = last_nib ? '0 : idx_q + 1'b1;
            if (last_nib) begin
                // Overflow when carry into the sign bit differs from carry out.
                v_d = slice_c2 ^ slice_c3;
`ifdef SERIAL_ADDSUB_SAT_EN
                if (slice_c2 ^ slice_c3) begin
                    result_d = op_a_q[WIDTH-1] ? WIDTH'(SAT_NEG) : WIDTH'(SAT_POS);
                end
`endif
                z_d = (result_d == '0);
                n_d = result_d[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub16.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub16
// Directed bench: a table of operand/expected-result records applied in a
// loop, followed by hand-written handshake, flush and reset sequences.
// ---------------------------------------------------------------------------
module tb_serial_addsub16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Result;
    logic        Z;
    logic        N;
    logic        V;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        v;
    } vec_t;

    vec_t vecs[10];

    serial_addsub16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .sub    (sub),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Z      (Z),
        .N      (N),
        .V      (V)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one operation and stop at the negedge of the done cycle
    // (done_cyc = 0 if done never arrives within the budget).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output int done_cyc, output int busy_cnt);
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cyc = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int dc, bc, t1, t2, dcount;
        string nm;

        // Vector table (hand-computed)
        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
`ifdef SERIAL_ADDSUB_SAT_EN
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1};
`else
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1};
`endif
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};

        // Reset
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; sub = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(Result), 32'd0);
        check("reset_flags", 32'({Z, N, V}), 32'd0);

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, dc, bc);
            nm = $sformatf("vec%0d", i);
            check({nm, "_latency"}, 32'(dc), 32'd5);
            check({nm, "_busy_cycles"}, 32'(bc), 32'd4);
            check({nm, "_result"}, 32'(Result), 32'(vecs[i].res));
            check({nm, "_flags_znv"}, 32'({Z, N, V}),
                  32'({vecs[i].z, vecs[i].n, vecs[i].v}));
            @(negedge clk);
            check({nm, "_done_pulse"}, 32'(done), 32'd0);
            check({nm, "_hold_result"}, 32'(Result), 32'(vecs[i].res));
        end

        // Back-to-back: start held high through DONE
        @(negedge clk);
        A = 16'h0001; B = 16'h0002; sub = 1'b0; start = 1'b1;
        t1 = 0; t2 = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                if (t1 == 0) begin
                    t1 = c;
                    check("b2b_first_result", 32'(Result), 32'h0003);
                    A = 16'h0010; B = 16'h0001; sub = 1'b1;
                end else begin
                    t2 = c;
                    check("b2b_second_result", 32'(Result), 32'h000F);
                    check("b2b_second_flags", 32'({Z, N, V}), 32'd0);
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_latency", 32'(t1), 32'd5);
        check("b2b_gap", 32'(t2 - t1), 32'd5);
        @(negedge clk);
        check("b2b_idle_after", 32'({busy, done}), 32'd0);

        // start during RUN is ignored
        @(negedge clk);
        A = 16'h1111; B = 16'h1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = 0;
        for (int c = 3; c <= 20; c++) begin
            if (done) begin
                dc = c;
                break;
            end
            @(negedge clk);
        end
        check("run_start_latency", 32'(dc), 32'd5);
        check("run_start_result", 32'(Result), 32'h2222);
        @(negedge clk);
        check("run_start_not_queued", 32'(busy), 32'd0);

        // Flush in RUN cycle 2: set known flags first (Z=1,N=0,V=0)
        do_op(16'h8000, 16'h8000, 1'b1, dc, bc);
        check("pre_flush_flags", 32'({Z, N, V}), 32'b100);
        @(negedge clk);
        A = 16'h7FFF; B = 16'h0001; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle_next", 32'({busy, done}), 32'd0);
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("flush_no_done", 32'(dcount), 32'd0);
        check("flush_flags_kept", 32'({Z, N, V}), 32'b100);
        do_op(16'h1234, 16'h0FCD, 1'b0, dc, bc);
        check("post_flush_latency", 32'(dc), 32'd5);
        check("post_flush_result", 32'(Result), 32'h2201);

        // flush with start in IDLE suppresses the start
        @(negedge clk);
        @(negedge clk);
        A = 16'h0001; B = 16'h0001; sub = 1'b0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_idle_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("flush_idle_start_done", 32'({busy, done}), 32'd0);
        check("flush_idle_result", 32'(Result), 32'h2201);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        A = 16'h1234; B = 16'h0FCD; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_result", 32'(Result), 32'd0);
        check("rst_mid_flags", 32'({Z, N, V}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("rst_release_quiet", 32'(dcount), 32'd0);
        check("rst_release_result", 32'(Result), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
